// File: rtl/des_core.sv
// Iterative DES engine: one Feistel round per clock, 18 cycles per block,
// with an optional odd-parity check on the key before a block is accepted.
module des_core (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [63:0] data_in,
   input  logic [63:0] key_in,
   input  logic        mode_in,
   input  logic        verify_in,
   input  logic        encrypt_in_valid,
   output logic [63:0] encrypt_out,
   output logic        encrypt_out_valid,
   output logic        encrypt_ready,
   output logic        encrypt_err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   localparam int SBOX [8][64] = '{
      '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
      '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
      '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
      '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
      '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
      '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
      '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
      '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

   // Tables number bits 1..N from the MSB, so DES bit k sits at index N-k.
   function automatic logic [63:0] ip_f(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
      return y;
   endfunction

   function automatic logic [63:0] fp_f(input logic [63:0] x);
      logic [63:0] y;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
      return y;
   endfunction

   function automatic logic [47:0] e_f(input logic [31:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
      return y;
   endfunction

   function automatic logic [31:0] p_f(input logic [31:0] x);
      logic [31:0] y;
      for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
      return y;
   endfunction

   function automatic logic [55:0] pc1_f(input logic [63:0] x);
      logic [55:0] y;
      for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
      return y;
   endfunction

   function automatic logic [47:0] pc2_f(input logic [55:0] x);
      logic [47:0] y;
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
      return y;
   endfunction

   // Outer bits of each 6-bit group select the row, inner four the column.
   function automatic logic [31:0] sbox_f(input logic [47:0] x);
      logic [31:0] y;
      logic [5:0]  six;
      y = '0;
      for (int b = 0; b < 8; b++) begin
         six = 6'(x >> (42 - 6 * b));
         y   = {y[27:0], 4'(SBOX[3'(b)][{six[5], six[0], six[4:1]}])};
      end
      return y;
   endfunction

   state_t      state, state_nxt;
   logic [31:0] l, r;
   logic [27:0] c, d;
   logic [27:0] c_rot, d_rot;
   logic [3:0]  round;
   logic        mode_q;
   logic        key_bad;
   logic        shift_two;
   logic [31:0] f_out;

   always_comb begin
      key_bad = 1'b0;
      for (int b = 0; b < 8; b++) begin
         if (!(^8'(key_in >> (8 * b)))) key_bad = 1'b1;
      end
   end

   // Decrypt walks the schedule backwards: round 0 reuses C0/D0 (== C16/D16).
   always_comb begin
      shift_two = !(round == 4'd0 || round == 4'd1 || round == 4'd8 || round == 4'd15);
      c_rot     = c;
      d_rot     = d;
      if (!mode_q) begin
         c_rot = shift_two ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
         d_rot = shift_two ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
      end else if (round != 4'd0) begin
         c_rot = shift_two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
         d_rot = shift_two ? {d[1:0], d[27:2]} : {d[0], d[27:1]};
      end
      f_out = p_f(sbox_f(e_f(r) ^ pc2_f({c_rot, d_rot})));
   end

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (encrypt_in_valid) state_nxt = (verify_in && key_bad) ? ERR : RUN;
         RUN:     if (round == 4'd15) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign encrypt_ready = (state == IDLE);

   // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= IDLE;
      else           state <= state_nxt;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         l                 <= '0;
         r                 <= '0;
         c                 <= '0;
         d                 <= '0;
         round             <= '0;
         mode_q            <= 1'b0;
         encrypt_out       <= '0;
         encrypt_out_valid <= 1'b0;
         encrypt_err       <= 1'b0;
      end else begin
         encrypt_out_valid <= (state == RUN) && (round == 4'd15);
         encrypt_err       <= (state_nxt == ERR);
         if (state == IDLE && state_nxt == RUN) begin
            {l, r} <= ip_f(data_in);
            {c, d} <= pc1_f(key_in);
            round  <= '0;
            mode_q <= mode_in;
         end else if (state == RUN) begin
            l     <= r;
            r     <= l ^ f_out;
            c     <= c_rot;
            d     <= d_rot;
            round <= round + 4'd1;
            // Final output swaps the halves: FP(R16 || L16).
            if (round == 4'd15) encrypt_out <= fp_f({l ^ f_out, r});
         end
      end
   end

endmodule

// File: tb/tb_des_core.sv
// Bench for des_core: known-answer vectors, timing, parity errors, mid-run
// reset and random blocks scored against a textbook DES model.
module tb_des_core;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [63:0] data_in = '0;
   logic [63:0] key_in = '0;
   logic        mode_in = 1'b0;
   logic        verify_in = 1'b0;
   logic        encrypt_in_valid = 1'b0;
   logic [63:0] encrypt_out;
   logic        encrypt_out_valid;
   logic        encrypt_ready;
   logic        encrypt_err;

   int          checks = 0;
   int          failures = 0;
   logic [63:0] exp_out = '0;

   des_core dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .data_in(data_in), .key_in(key_in),
      .mode_in(mode_in), .verify_in(verify_in), .encrypt_in_valid(encrypt_in_valid),
      .encrypt_out(encrypt_out), .encrypt_out_valid(encrypt_out_valid),
      .encrypt_ready(encrypt_ready), .encrypt_err(encrypt_err)
   );

   always #5 clk_in = ~clk_in;

   int ip_t[$]  = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                    57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
   int fp_t[$]  = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                    36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
   int e_t[$]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                    16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
   int p_t[$]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
   int pc1_t[$] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
   int pc2_t[$] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
   int sb[8][64] = '{
      '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
      '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
      '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
      '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
      '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
      '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
      '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
      '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

   // Picks bits of an in_w-bit value (bit 1 = MSB) in table order; result is right-aligned.
   function automatic logic [63:0] perm(input logic [63:0] x, input int in_w, input int t[$]);
      logic [63:0] y = '0;
      foreach (t[i]) y = (y << 1) | ((x >> (in_w - t[i])) & 64'd1);
      return y;
   endfunction

   // Textbook DES: build K1..K16 up front, decrypt simply uses them in reverse.
   function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] data, input bit decrypt);
      int          shifts[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
      logic [47:0] ks[16];
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [63:0] lr;
      logic [31:0] l, r, f, tmp;
      logic [47:0] x;
      logic [5:0]  six;
      cd = 56'(perm(key, 64, pc1_t));
      c = cd[55:28];
      d = cd[27:0];
      for (int i = 0; i < 16; i++) begin
         c = (c << shifts[i]) | (c >> (28 - shifts[i]));
         d = (d << shifts[i]) | (d >> (28 - shifts[i]));
         ks[i] = 48'(perm({8'h0, c, d}, 56, pc2_t));
      end
      lr = perm(data, 64, ip_t);
      l = lr[63:32];
      r = lr[31:0];
      for (int i = 0; i < 16; i++) begin
         x = 48'(perm({32'h0, r}, 32, e_t)) ^ ks[decrypt ? 15 - i : i];
         f = '0;
         for (int b = 0; b < 8; b++) begin
            six = 6'(x >> (42 - 6 * b));
            f = (f << 4) | 32'(sb[b][32 * six[5] + 16 * six[0] + int'(six[4:1])]);
         end
         f = 32'(perm({32'h0, f}, 32, p_t));
         tmp = r;
         r = l ^ f;
         l = tmp;
      end
      return perm({r, l}, 64, fp_t);
   endfunction

   function automatic bit key_odd(input logic [63:0] key);
      for (int b = 0; b < 8; b++) if ($countones(8'(key >> (8 * b))) % 2 == 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [63:0] fix_parity(input logic [63:0] key);
      logic [63:0] k = key;
      for (int b = 0; b < 8; b++) if ($countones(8'(k >> (8 * b))) % 2 == 0) k = k ^ (64'd1 << (8 * b));
      return k;
   endfunction

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk_in);
         if (encrypt_ready) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Drives one request; returns just after the accepting edge.
   task automatic issue(input logic [63:0] key, input logic [63:0] data, input bit mode, input bit verify,
                        output bit ok);
      wait_ready(ok);
      key_in = key;
      data_in = data;
      mode_in = mode;
      verify_in = verify;
      encrypt_in_valid = 1'b1;
      @(posedge clk_in);
      #1 encrypt_in_valid = 1'b0;
   endtask

   // k counts negedges after the accepting edge: k = 0 is the cycle after it.
   task automatic collect(input int n_cyc, output int k_valid, output int k_err, output int n_valid,
                          output int n_err, output logic [63:0] out, output logic [2:0] rdy);
      k_valid = -1; k_err = -1; n_valid = 0; n_err = 0; rdy = '0; out = 'x;
      for (int k = 0; k < n_cyc; k++) begin
         @(negedge clk_in);
         if (encrypt_out_valid) begin
            n_valid++;
            if (k_valid < 0) begin k_valid = k; out = encrypt_out; end
         end
         if (encrypt_err) begin
            n_err++;
            if (k_err < 0) k_err = k;
         end
         if (k == 0)  rdy[0] = encrypt_ready;
         if (k == 1)  rdy[1] = encrypt_ready;
         if (k == 17) rdy[2] = encrypt_ready;
      end
      if (k_valid < 0) out = encrypt_out;
   endtask

   task automatic test_reset;
      @(posedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      #1;
      checks++; if (encrypt_out !== 64'h0) begin failures++; $display("FAIL reset_out: got %h want 0", encrypt_out); end
      checks++; if (encrypt_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", encrypt_out_valid); end
      checks++; if (encrypt_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", encrypt_err); end
      checks++; if (encrypt_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", encrypt_ready); end
   endtask

   task automatic test_encrypt;
      bit ok; int kv, ke, nv, ne; logic [63:0] o; logic [2:0] rdy;
      issue(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 1'b1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL enc_issue: ready timeout"); end
      collect(20, kv, ke, nv, ne, o, rdy);
      exp_out = 64'h85E813540F0AB405;
      checks++; if (o !== exp_out) begin failures++; $display("FAIL enc_out: got %h want %h", o, exp_out); end
      checks++; if (kv !== 16) begin failures++; $display("FAIL enc_latency: got %0d want 16", kv); end
      checks++; if (nv !== 1) begin failures++; $display("FAIL enc_strobe_len: got %0d want 1", nv); end
      checks++; if (ne !== 0) begin failures++; $display("FAIL enc_err: got %0d pulses want 0", ne); end
      checks++; if (rdy !== 3'b100) begin failures++; $display("FAIL enc_ready: got %b want 100", rdy); end
      checks++; if (encrypt_out !== exp_out) begin failures++; $display("FAIL enc_hold: got %h want %h", encrypt_out, exp_out); end
   endtask

   task automatic test_decrypt;
      bit ok; int kv, ke, nv, ne; logic [63:0] o; logic [2:0] rdy;
      issue(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 1'b0, ok);
      checks++; if (!ok) begin failures++; $display("FAIL dec_issue: ready timeout"); end
      collect(20, kv, ke, nv, ne, o, rdy);
      exp_out = 64'h0123456789ABCDEF;
      checks++; if (o !== exp_out) begin failures++; $display("FAIL dec_out: got %h want %h", o, exp_out); end
      checks++; if (kv !== 16) begin failures++; $display("FAIL dec_latency: got %0d want 16", kv); end
   endtask

   // Valid stays high through the first block; the second is taken at the first ready.
   task automatic test_back_to_back;
      bit ok; int k1 = -1, k2 = -1; logic [63:0] o1 = 'x, o2 = 'x; logic r17 = 1'bx, r18 = 1'bx;
      wait_ready(ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_issue: ready timeout"); end
      key_in = 64'h133457799BBCDFF1; data_in = 64'h0123456789ABCDEF; mode_in = 1'b0; verify_in = 1'b1;
      encrypt_in_valid = 1'b1;
      @(posedge clk_in);
      #1 key_in = 64'h0E329232EA6D0D73; data_in = 64'h8787878787878787;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk_in);
         if (encrypt_out_valid) begin
            if (k1 < 0) begin k1 = k; o1 = encrypt_out; end
            else if (k2 < 0) begin k2 = k; o2 = encrypt_out; end
         end
         if (k == 17) r17 = encrypt_ready;
         if (k == 18) begin r18 = encrypt_ready; encrypt_in_valid = 1'b0; end
      end
      exp_out = 64'h0000000000000000;
      checks++; if (o1 !== 64'h85E813540F0AB405) begin failures++; $display("FAIL b2b_out1: got %h want 85e813540f0ab405", o1); end
      checks++; if (k1 !== 16) begin failures++; $display("FAIL b2b_lat1: got %0d want 16", k1); end
      checks++; if (r17 !== 1'b1 || r18 !== 1'b0) begin failures++; $display("FAIL b2b_ready: got %b%b want 10", r17, r18); end
      checks++; if (o2 !== exp_out) begin failures++; $display("FAIL b2b_out2: got %h want %h", o2, exp_out); end
      checks++; if (k2 !== 34) begin failures++; $display("FAIL b2b_lat2: got %0d want 34", k2); end
   endtask

   task automatic test_parity_error;
      bit ok; int kv, ke, nv, ne; logic [63:0] o; logic [2:0] rdy;
      issue(64'h0, 64'h0, 1'b0, 1'b1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL perr_issue: ready timeout"); end
      collect(20, kv, ke, nv, ne, o, rdy);
      checks++; if (ke !== 0 || ne !== 1) begin failures++; $display("FAIL perr_err: got at %0d x%0d want at 0 x1", ke, ne); end
      checks++; if (nv !== 0) begin failures++; $display("FAIL perr_valid: got %0d strobes want 0", nv); end
      checks++; if (o !== exp_out) begin failures++; $display("FAIL perr_hold: got %h want %h", o, exp_out); end
      checks++; if (rdy[1:0] !== 2'b10) begin failures++; $display("FAIL perr_ready: got %b want 10", rdy[1:0]); end
      issue(64'h0, 64'h0, 1'b0, 1'b0, ok);
      collect(20, kv, ke, nv, ne, o, rdy);
      exp_out = 64'h8CA64DE9C1B123A7;
      checks++; if (o !== exp_out || ne !== 0) begin failures++; $display("FAIL perr_noverify: got %h err %0d want %h err 0", o, ne, exp_out); end
   endtask

   task automatic test_mid_run_reset;
      bit ok; int kv, ke, nv, ne; logic [63:0] o, key, data; logic [2:0] rdy;
      key = {$urandom, $urandom}; data = {$urandom, $urandom};
      issue(key, data, 1'b0, 1'b0, ok);
      repeat (8) @(posedge clk_in);
      #2 rst_n_in = 1'b0;
      #1;
      exp_out = 64'h0;
      checks++; if (encrypt_ready !== 1'b1) begin failures++; $display("FAIL mrst_ready: got %b want 1", encrypt_ready); end
      checks++; if (encrypt_out !== 64'h0 || encrypt_out_valid !== 1'b0 || encrypt_err !== 1'b0)
         begin failures++; $display("FAIL mrst_outs: got %h/%b/%b want 0/0/0", encrypt_out, encrypt_out_valid, encrypt_err); end
      @(posedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      collect(20, kv, ke, nv, ne, o, rdy);
      checks++; if (nv !== 0 || ne !== 0) begin failures++; $display("FAIL mrst_strobe: got %0d/%0d want 0/0", nv, ne); end
      key = {$urandom, $urandom}; data = {$urandom, $urandom};
      issue(key, data, 1'b1, 1'b0, ok);
      collect(20, kv, ke, nv, ne, o, rdy);
      exp_out = des_model(key, data, 1'b1);
      checks++; if (o !== exp_out || kv !== 16) begin failures++; $display("FAIL mrst_after: got %h at %0d want %h at 16", o, kv, exp_out); end
   endtask

   task automatic test_random;
      bit ok, mode, verify, bad; int kv, ke, nv, ne; logic [63:0] o, key, data; logic [2:0] rdy;
      for (int n = 0; n < 24; n++) begin
         key = {$urandom, $urandom}; data = {$urandom, $urandom};
         mode = 1'($urandom); verify = 1'($urandom);
         if (verify && $urandom_range(1, 0) == 1) key = fix_parity(key);
         bad = verify && !key_odd(key);
         issue(key, data, mode, verify, ok);
         collect(20, kv, ke, nv, ne, o, rdy);
         if (bad) begin
            checks++; if (ke !== 0 || ne !== 1 || nv !== 0 || o !== exp_out)
               begin failures++; $display("FAIL rand_err[%0d]: err at %0d x%0d valid x%0d out %h want err at 0 x1 out %h", n, ke, ne, nv, o, exp_out); end
         end else begin
            exp_out = des_model(key, data, mode);
            checks++; if (o !== exp_out || kv !== 16 || ne !== 0)
               begin failures++; $display("FAIL rand_out[%0d]: got %h at %0d err x%0d want %h at 16", n, o, kv, ne, exp_out); end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_back_to_back();
      test_parity_error();
      test_mid_run_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
